// File: rtl/qam_burst_scheduler.sv
// Symbol burst scheduler: buffers modulator symbols and releases them to the DAC at a fixed
// symbol rate as preamble / payload / guard bursts, flagging underrun and framing errors.
module qam_burst_scheduler #(
  parameter int unsigned         DATA_W     = 33,
  parameter int unsigned         FIFO_DEPTH = 16,
  parameter int unsigned         SYM_DIV    = 4,
  parameter int unsigned         PRE_LEN    = 8,
  parameter int unsigned         GUARD_LEN  = 4,
  parameter int unsigned         START_LVL  = 8,
  parameter logic [DATA_W-1:0]   PRE_SYM    = 33'h0_7FFF_7FFF
) (
  input  logic              csi_clk,
  input  logic              rsi_reset,
  input  logic [DATA_W-1:0] asi_in0_data,
  input  logic              asi_in0_valid,
  output logic              asi_in0_ready,
  input  logic              asi_in0_startofpacket,
  input  logic              asi_in0_endofpacket,
  input  logic              coe_enable,
  output logic [DATA_W-1:0] coe_dac_data,
  output logic              coe_dac_strobe,
  output logic              coe_tx_active,
  output logic              coe_underrun,
  output logic              coe_error
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned TickW  = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam int unsigned SymMax = (PRE_LEN > GUARD_LEN) ? PRE_LEN : GUARD_LEN;
  localparam int unsigned SymW   = $clog2(SymMax + 1);

  localparam logic [CntW-1:0]  FullCnt   = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0]  StartCnt  = CntW'(START_LVL);
  localparam logic [TickW-1:0] TickLast  = TickW'(SYM_DIV - 1);
  localparam logic [SymW-1:0]  PreLast   = SymW'(PRE_LEN - 1);
  localparam logic [SymW-1:0]  GuardLast = SymW'(GUARD_LEN - 1);

  typedef enum logic [1:0] {StIdle, StPre, StPay, StGuard} state_e;

  logic [DATA_W+1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d, eop_cnt_q, eop_cnt_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [SymW-1:0]   sym_cnt_q, sym_cnt_d;
  state_e            state_q, state_d;
  logic              first_q, first_d;

  logic [DATA_W-1:0] dac_data_q, dac_data_d;
  logic              strobe_q, strobe_d, active_q, active_d;
  logic              underrun_q, underrun_d, error_q, error_d;

  logic              push, pop, tick, empty, start_ok;
  logic [DATA_W+1:0] head;
  logic              head_sop, head_eop;

  assign head          = mem_q[rd_ptr_q];
  assign head_sop      = head[DATA_W];
  assign head_eop      = head[DATA_W+1];
  assign empty         = (count_q == '0);
  assign asi_in0_ready = (count_q != FullCnt);
  assign push          = asi_in0_valid && asi_in0_ready;
  assign tick          = (tick_cnt_q == TickLast);
  assign start_ok      = coe_enable && !empty && head_sop &&
                         ((count_q >= StartCnt) || (eop_cnt_q != '0));

  always_ff @(posedge csi_clk) begin
    if (push) mem_q[wr_ptr_q] <= {asi_in0_endofpacket, asi_in0_startofpacket, asi_in0_data};
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    eop_cnt_d = eop_cnt_q;
    if ((push && asi_in0_endofpacket) && !(pop && head_eop))      eop_cnt_d = eop_cnt_q + 1'b1;
    else if (!(push && asi_in0_endofpacket) && (pop && head_eop)) eop_cnt_d = eop_cnt_q - 1'b1;
  end

  // State register
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      eop_cnt_q  <= '0;
      tick_cnt_q <= '0;
      sym_cnt_q  <= '0;
      state_q    <= StIdle;
      first_q    <= 1'b0;
      dac_data_q <= '0;
      strobe_q   <= 1'b0;
      active_q   <= 1'b0;
      underrun_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      eop_cnt_q  <= eop_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      state_q    <= state_d;
      first_q    <= first_d;
      dac_data_q <= dac_data_d;
      strobe_q   <= strobe_d;
      active_q   <= active_d;
      underrun_q <= underrun_d;
      error_q    <= error_d;
    end
  end

  // Next state, symbol counter and FIFO pop
  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    first_d   = first_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Words without SOP cannot start a burst; drop them at full clock rate.
        if (!empty && !head_sop) begin
          pop = 1'b1;
        end else if (tick && start_ok) begin
          first_d   = 1'b1;
          sym_cnt_d = SymW'(1);
          state_d   = (PRE_LEN == 1) ? StPay : StPre;
        end
      end
      StPre: begin
        if (tick) begin
          if (sym_cnt_q == PreLast) state_d = StPay;
          else                      sym_cnt_d = sym_cnt_q + 1'b1;
        end
      end
      StPay: begin
        if (tick && !empty) begin
          if (head_sop && !first_q) begin
            state_d   = StGuard;
            sym_cnt_d = '0;
          end else begin
            pop     = 1'b1;
            first_d = 1'b0;
            if (head_eop) begin
              state_d   = StGuard;
              sym_cnt_d = '0;
            end
          end
        end
      end
      StGuard: begin
        if (tick) begin
          if (sym_cnt_q == GuardLast) state_d = StIdle;
          else                        sym_cnt_d = sym_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered DAC outputs; tx_active tracks the symbol currently on the DAC
  always_comb begin
    dac_data_d = dac_data_q;
    strobe_d   = 1'b0;
    active_d   = active_q;
    underrun_d = 1'b0;
    error_d    = 1'b0;
    if (tick) begin
      strobe_d   = 1'b1;
      dac_data_d = '0;
      active_d   = (state_q != StIdle);
    end
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          error_d = 1'b1;
        end else if (tick && start_ok) begin
          dac_data_d = PRE_SYM;
          active_d   = 1'b1;
        end
      end
      StPre: begin
        if (tick) dac_data_d = PRE_SYM;
      end
      StPay: begin
        if (tick) begin
          if (empty)                     underrun_d = 1'b1;
          else if (head_sop && !first_q) error_d    = 1'b1;
          else                           dac_data_d = head[DATA_W-1:0];
        end
      end
      StGuard: ;
      default: ;
    endcase
  end

  assign coe_dac_data   = dac_data_q;
  assign coe_dac_strobe = strobe_q;
  assign coe_tx_active  = active_q;
  assign coe_underrun   = underrun_q;
  assign coe_error      = error_q;

endmodule

// File: tb/tb_qam_burst_scheduler.sv
// Directed bench for qam_burst_scheduler at default parameters.
module tb_qam_burst_scheduler;
  localparam logic [32:0] PRE = 33'h0_7FFF_7FFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [32:0] din = '0;
  logic        vld = 1'b0, sop = 1'b0, eop = 1'b0, en = 1'b0;
  logic        ready, strobe, tx_active, underrun, err;
  logic [32:0] dac_data;

  qam_burst_scheduler dut (
    .csi_clk               (clk),
    .rsi_reset             (rst),
    .asi_in0_data          (din),
    .asi_in0_valid         (vld),
    .asi_in0_ready         (ready),
    .asi_in0_startofpacket (sop),
    .asi_in0_endofpacket   (eop),
    .coe_enable            (en),
    .coe_dac_data          (dac_data),
    .coe_dac_strobe        (strobe),
    .coe_tx_active         (tx_active),
    .coe_underrun          (underrun),
    .coe_error             (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor: burst symbols and pulse counts, sampled on the falling edge.
  logic [32:0] sym_q[$];
  int active_clks = 0, underruns = 0, err_pulses = 0;
  always @(negedge clk) begin
    if (strobe === 1'b1 && tx_active === 1'b1) sym_q.push_back(dac_data);
    if (tx_active === 1'b1) active_clks++;
    if (underrun === 1'b1)  underruns++;
    if (err === 1'b1)       err_pulses++;
  end

  logic [32:0] exp_q[$];

  task automatic add_pre();
    for (int i = 0; i < 8; i++) exp_q.push_back(PRE);
  endtask

  task automatic add_guard();
    for (int i = 0; i < 4; i++) exp_q.push_back('0);
  endtask

  // Enter at a falling edge; returns at the falling edge after the accepting clock.
  task automatic push_word(input logic [32:0] d, input logic s, input logic e, output logic to);
    vld = 1'b1; din = d; sop = s; eop = e; to = 1'b0;
    for (int i = 0; i < 2000 && !ready; i++) @(negedge clk);
    if (!ready) to = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_in();
    vld = 1'b0; sop = 1'b0; eop = 1'b0; din = '0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_burst(input int budget, output logic to);
    int n;
    to = 1'b0;
    n = 0;
    while (!tx_active && n < budget) begin @(negedge clk); n++; end
    if (!tx_active) to = 1'b1;
    n = 0;
    while (tx_active && n < budget) begin @(negedge clk); n++; end
    if (tx_active) to = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_in(); en = 1'b0;
    wait_clks(3);
    checks++; if (dac_data !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", dac_data); end
    checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe got %b exp 0", strobe); end
    checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL rst_active got %b exp 0", tx_active); end
    checks++; if (underrun !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_pulses got %b%b exp 00", underrun, err);
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", ready); end
    rst = 1'b0;
    // First tick 3 clocks after release, strobe visible one clock later.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (strobe !== (k == 4)) begin
        errors++; $display("FAIL first_tick clk %0d got %b exp %b", k, strobe, (k == 4));
      end
    end
  endtask

  task automatic test_basic();
    int base, abase; logic to;
    base = sym_q.size(); abase = active_clks;
    en = 1'b1;
    push_word(33'h1, 1'b1, 1'b0, to);
    push_word(33'h2, 1'b0, 1'b0, to);
    push_word(33'h3, 1'b0, 1'b1, to);
    idle_in();
    wait_burst(400, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got 1 exp 0"); end
    exp_q.delete(); add_pre(); exp_q.push_back(33'h1); exp_q.push_back(33'h2);
    exp_q.push_back(33'h3); add_guard();
    checks++; if (sym_q.size() - base !== exp_q.size()) begin
      errors++; $display("FAIL basic_len got %0d exp %0d", sym_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < sym_q.size(); i++) begin
      checks++; if (sym_q[base+i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_sym[%0d] got %h exp %h", i, sym_q[base+i], exp_q[i]);
      end
    end
    checks++; if (active_clks - abase !== 60) begin
      errors++; $display("FAIL basic_active got %0d exp 60", active_clks - abase);
    end
  endtask

  task automatic test_enable();
    int base, abase, n; logic to;
    en = 1'b0; wait_clks(2);
    base = sym_q.size(); abase = active_clks;
    push_word(33'h1, 1'b1, 1'b0, to);
    push_word(33'h2, 1'b0, 1'b0, to);
    push_word(33'h3, 1'b0, 1'b1, to);
    idle_in();
    wait_clks(20);
    checks++; if (active_clks - abase !== 0) begin
      errors++; $display("FAIL en_hold got %0d exp 0", active_clks - abase);
    end
    en = 1'b1;
    n = 0;
    while (!tx_active && n < 20) begin @(negedge clk); n++; end
    checks++; if (n < 1 || n > 4) begin errors++; $display("FAIL en_start got %0d exp 1..4", n); end
    wait_burst(400, to);
    exp_q.delete(); add_pre(); exp_q.push_back(33'h1); exp_q.push_back(33'h2);
    exp_q.push_back(33'h3); add_guard();
    checks++; if (sym_q.size() - base !== exp_q.size() || to) begin
      errors++; $display("FAIL en_len got %0d exp %0d", sym_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < sym_q.size(); i++) begin
      checks++; if (sym_q[base+i] !== exp_q[i]) begin
        errors++; $display("FAIL en_sym[%0d] got %h exp %h", i, sym_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_level();
    int base, abase, ubase, u; logic to;
    base = sym_q.size(); abase = active_clks;
    push_word(33'h1, 1'b1, 1'b0, to);
    push_word(33'h2, 1'b0, 1'b0, to);
    idle_in();
    wait_clks(40);
    checks++; if (active_clks - abase !== 0) begin
      errors++; $display("FAIL lvl_nostart got %0d exp 0", active_clks - abase);
    end
    push_word(33'h3, 1'b0, 1'b1, to);
    idle_in();
    wait_burst(400, to);
    checks++; if (sym_q.size() - base !== 15 || to) begin
      errors++; $display("FAIL lvl_eop_len got %0d exp 15", sym_q.size() - base);
    end
    // Fill-triggered start: eight words reach the start level exactly.
    base = sym_q.size(); abase = active_clks; ubase = underruns;
    for (int i = 0; i < 8; i++) push_word(33'h10 + 33'(i), (i == 0), 1'b0, to);
    idle_in();
    wait_clks(40);
    checks++; if (active_clks - abase == 0) begin
      errors++; $display("FAIL lvl_fill_start got 0 exp >0");
    end
    push_word(33'h18, 1'b0, 1'b0, to);
    idle_in();
    wait_clks(100);
    push_word(33'h19, 1'b0, 1'b1, to);
    idle_in();
    wait_burst(400, to);
    u = underruns - ubase;
    checks++; if (u < 1) begin errors++; $display("FAIL lvl_underrun got %0d exp >=1", u); end
    exp_q.delete(); add_pre();
    for (int i = 0; i < 9; i++) exp_q.push_back(33'h10 + 33'(i));
    for (int i = 0; i < u; i++) exp_q.push_back('0);
    exp_q.push_back(33'h19); add_guard();
    checks++; if (sym_q.size() - base !== exp_q.size() || to) begin
      errors++; $display("FAIL lvl_fill_len got %0d exp %0d", sym_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < sym_q.size(); i++) begin
      checks++; if (sym_q[base+i] !== exp_q[i]) begin
        errors++; $display("FAIL lvl_sym[%0d] got %h exp %h", i, sym_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base, ubase; logic to;
    base = sym_q.size(); ubase = underruns;
    for (int i = 0; i < 20; i++) begin
      push_word(33'h100 + 33'(i), (i == 0), (i == 19), to);
      if (i == 14) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL bp_ready15 got %b exp 1", ready); end
      end
      if (i == 15) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bp_ready16 got %b exp 0", ready); end
      end
    end
    idle_in();
    wait_burst(800, to);
    exp_q.delete(); add_pre();
    for (int i = 0; i < 20; i++) exp_q.push_back(33'h100 + 33'(i));
    add_guard();
    checks++; if (sym_q.size() - base !== exp_q.size() || to) begin
      errors++; $display("FAIL bp_len got %0d exp %0d", sym_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < sym_q.size(); i++) begin
      checks++; if (sym_q[base+i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_sym[%0d] got %h exp %h", i, sym_q[base+i], exp_q[i]);
      end
    end
    checks++; if (underruns - ubase !== 0) begin
      errors++; $display("FAIL bp_underrun got %0d exp 0", underruns - ubase);
    end
  endtask

  task automatic test_framing();
    int base, abase, ebase; logic to;
    abase = active_clks; ebase = err_pulses;
    push_word(33'hA, 1'b0, 1'b0, to);
    idle_in();
    wait_clks(12);
    checks++; if (err_pulses - ebase !== 1) begin
      errors++; $display("FAIL frm_discard got %0d exp 1", err_pulses - ebase);
    end
    checks++; if (active_clks - abase !== 0 || ready !== 1'b1) begin
      errors++; $display("FAIL frm_noburst got %0d/%b exp 0/1", active_clks - abase, ready);
    end
    base = sym_q.size(); ebase = err_pulses;
    push_word(33'h1, 1'b1, 1'b0, to);
    push_word(33'h2, 1'b0, 1'b0, to);
    push_word(33'h5, 1'b1, 1'b0, to);
    push_word(33'h6, 1'b0, 1'b0, to);
    push_word(33'h7, 1'b0, 1'b1, to);
    idle_in();
    wait_burst(800, to);
    exp_q.delete(); add_pre(); exp_q.push_back(33'h1); exp_q.push_back(33'h2);
    exp_q.push_back('0); add_guard();
    add_pre(); exp_q.push_back(33'h5); exp_q.push_back(33'h6); exp_q.push_back(33'h7);
    add_guard();
    checks++; if (sym_q.size() - base !== exp_q.size() || to) begin
      errors++; $display("FAIL frm_len got %0d exp %0d", sym_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < sym_q.size(); i++) begin
      checks++; if (sym_q[base+i] !== exp_q[i]) begin
        errors++; $display("FAIL frm_sym[%0d] got %h exp %h", i, sym_q[base+i], exp_q[i]);
      end
    end
    checks++; if (err_pulses - ebase !== 1) begin
      errors++; $display("FAIL frm_missing_eop got %0d exp 1", err_pulses - ebase);
    end
  endtask

  task automatic test_reset_abort();
    int base, abase, ebase, n; logic to;
    base = sym_q.size();
    push_word(33'h1, 1'b1, 1'b0, to);
    push_word(33'h2, 1'b0, 1'b0, to);
    push_word(33'h3, 1'b0, 1'b0, to);
    push_word(33'h4, 1'b0, 1'b1, to);
    idle_in();
    n = 0;
    while (sym_q.size() - base < 9 && n < 400) begin @(negedge clk); n++; end
    checks++; if (sym_q.size() - base < 9) begin
      errors++; $display("FAIL abort_reach got %0d exp 9", sym_q.size() - base);
    end
    rst = 1'b1;
    #1;
    checks++; if (dac_data !== '0 || strobe !== 1'b0 || tx_active !== 1'b0) begin
      errors++; $display("FAIL abort_out got %h/%b/%b exp 0/0/0", dac_data, strobe, tx_active);
    end
    checks++; if (underrun !== 1'b0 || err !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL abort_flags got %b/%b/%b exp 0/0/1", underrun, err, ready);
    end
    wait_clks(2);
    rst = 1'b0;
    abase = active_clks; ebase = err_pulses;
    wait_clks(60);
    checks++; if (active_clks - abase !== 0 || err_pulses - ebase !== 0) begin
      errors++; $display("FAIL abort_flush got %0d/%0d exp 0/0", active_clks - abase,
                         err_pulses - ebase);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enable();
    test_start_level();
    test_backpressure();
    test_framing();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end
endmodule

// File: doc/qam_burst_scheduler.md
# qam_burst_scheduler

Burst scheduler between the QAM modulator's Avalon-ST symbol output and the DAC interface. Buffers modulator symbols in a small FIFO and releases them at a fixed symbol rate as framed bursts: preamble, payload, then guard. Keeps the DAC symbol stream gap-free inside a burst and signals underrun and framing errors to the control plane.

## Interface
- DATA_W, 33, symbol width; opaque I/Q word.
- FIFO_DEPTH, 16, FIFO entries; power of 2, at least 4.
- SYM_DIV, 4, clocks per symbol tick; at least 1.
- PRE_LEN, 8, preamble symbols per burst; at least 1.
- GUARD_LEN, 4, zero symbols after each burst; at least 1.
- START_LVL, 8, FIFO fill level that starts a burst; at most FIFO_DEPTH.
- PRE_SYM, 33'h0_7FFF_7FFF, preamble symbol value.
- csi_clk  in  1  single clock.
- rsi_reset  in  1  asynchronous, active-high reset.
- asi_in0_data  in  DATA_W  symbol from the modulator.
- asi_in0_valid  in  1  input valid.
- asi_in0_ready  out  1  input ready.
- asi_in0_startofpacket  in  1  first symbol of a packet.
- asi_in0_endofpacket  in  1  last symbol of a packet.
- coe_enable  in  1  allows new bursts to start.
- coe_dac_data  out  DATA_W  registered DAC symbol.
- coe_dac_strobe  out  1  one-clock pulse; coe_dac_data is new this cycle.
- coe_tx_active  out  1  high in PREAMBLE, PAYLOAD and GUARD.
- coe_underrun  out  1  one-clock pulse on a payload tick with an empty FIFO.
- coe_error  out  1  one-clock pulse on a framing error or a discarded word.

## Operation
- FIFO entry is {eop, sop, data}. A push happens when valid and ready are both high. asi_in0_ready = !full, decoded from the registered count.
- eop_cnt counts EOP words held in the FIFO. It increments on an EOP push and decrements on an EOP pop; a push and a pop in the same cycle cancel.
- Tick counter runs freely from 0 to SYM_DIV-1. tick is high when the count equals SYM_DIV-1. All symbol emission and state transitions occur only on tick.
- IDLE:
  - Each tick emits 0 with a strobe.
  - If the FIFO head lacks SOP, the head is popped on every clock, with no tick required, and coe_error pulses.
  - On a tick, move to PREAMBLE when coe_enable=1, the head has SOP, and (count >= START_LVL or eop_cnt > 0). That tick already emits PRE_SYM and counts as preamble symbol 1.
- PREAMBLE: emits PRE_SYM for PRE_LEN ticks in total, then moves to PAYLOAD.
- PAYLOAD, on each tick:
  - FIFO empty: emit 0, pulse coe_underrun, stay in PAYLOAD.
  - Head has SOP but is not the burst's first word: do not pop, emit 0, pulse coe_error, go to GUARD. This is a missing EOP.
  - Otherwise pop and emit the head. If the head has EOP, go to GUARD.
- GUARD: emits 0 for GUARD_LEN ticks, then returns to IDLE. The next burst can start on the tick after the last guard tick.
- coe_enable is examined only in IDLE. A burst in progress always completes.
- An SOP word with EOP also set forms a 1-symbol payload.

## Timing
- Reset values:
  - coe_dac_data=0, coe_dac_strobe=0, coe_tx_active=0, coe_underrun=0, coe_error=0.
  - asi_in0_ready=1 once the FIFO is empty.
  - FIFO empty, eop_cnt=0, tick counter=0, state=IDLE.
- Assertion of rsi_reset mid-burst aborts immediately and flushes the FIFO. There is no guard after the abort.
- First tick occurs SYM_DIV-1 clocks after reset release.
- coe_dac_data, coe_dac_strobe and coe_tx_active are registered. They update at the clock edge ending the tick cycle, so the strobe is visible one clock after tick.
- A pushed word is poppable from the next clock. Minimum input-to-DAC latency is 1 clock plus the wait to the next tick.
- Push while full cannot occur because ready=0. A simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full is count==FIFO_DEPTH.

## Test plan
- Default parameters, enable=1, push packet 0x1 (SOP), 0x2, 0x3 (EOP) -> over 15 strobes: 8×PRE_SYM, 0x1, 0x2, 0x3, 4×0x0. coe_tx_active is high for exactly 60 clocks.
- Enable=0, push the same packet; raise enable 20 clocks later -> no burst before enable. The burst starts on the first tick after enable rises, with identical output.
- Push 0x1 (SOP) and 0x2, hold 10 symbol periods, then push 0x3 (EOP) -> no start, since count 2 is below START_LVL and eop_cnt=0. The burst starts after the EOP push. Next, push 9 words without EOP and stall input -> the start is triggered by fill. Each empty payload tick emits 0 with an underrun pulse.
- Push 20 words with valid held high -> ready drops once 16 words are buffered and recovers as the burst drains. No word is lost or duplicated.
- Push 0xA (no SOP) in IDLE -> popped, error pulse, no burst. Packet SOP 0x1, 0x2, then SOP 0x5 … EOP -> after 0x2, emit 0 with an error pulse and guard. The 0x5 packet then follows as its own full burst.
- Assert reset during PAYLOAD -> all outputs reach their reset values immediately, the FIFO is empty, and ready=1.
